// File: rtl/cdc_src_arb_clear_ctrl.sv
// Round-robin arbiter onto a CDC source port plus the crossing clear sequencer.
// Optional clear watchdog: define CDC_CLR_TIMEOUT_EN (adds TIMEOUT_CYC counter and sticky clear_err_o).
module cdc_src_arb_clear_ctrl #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 34,
    parameter int ID_W        = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [DATA_W-1:0]         cdc_data_o,
    output logic                      cdc_valid_o,
    input  logic                      cdc_ready_i,
    output logic [ID_W-1:0]           gnt_id_o,
    input  logic                      clear_req_i,
    output logic                      cdc_clear_o,
    input  logic                      cdc_clear_pending_i,
    output logic                      clear_busy_o,
    output logic                      clear_done_o,
    output logic                      clear_err_o,
    output logic [2:0]                dbg_state_o
);

    // Valid/ready: a beat transfers on any cycle with cdc_valid_o & cdc_ready_i both high;
    // once valid is shown without ready, the grant is frozen (lock) until that beat transfers.

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DRAIN     = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_RISE = 3'd3,
        ST_WAIT_FALL = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic              lock_q;
    logic [ID_W-1:0]   lock_id_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic              found;
    logic [ID_W-1:0]   search_id;
    int                cand;
    logic [ID_W-1:0]   gnt_id;
    logic              gnt_valid;
    logic              handshake;
    logic [ID_W-1:0]   rr_next;
    logic              timeout;

    // Search upward from the RR pointer, wrapping modulo NUM_REQ.
    always_comb begin
        found     = 1'b0;
        search_id = '0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!found && req_valid_i[cand]) begin
                found     = 1'b1;
                search_id = ID_W'(cand);
            end
        end
    end

    always_comb begin
        gnt_id    = '0;
        gnt_valid = 1'b0;
        if (lock_q) begin
            gnt_id    = lock_id_q;
            gnt_valid = req_valid_i[lock_id_q];
        end else if (state_q == ST_IDLE && found) begin
            gnt_id    = search_id;
            gnt_valid = 1'b1;
        end
        // A clear pending from either side keeps the crossing quiet.
        if (cdc_clear_pending_i) begin
            gnt_valid = 1'b0;
        end
    end

    assign handshake = gnt_valid & cdc_ready_i;
    assign rr_next   = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

    always_comb begin
        req_ready_o = '0;
        if (gnt_valid && cdc_ready_i) begin
            req_ready_o[gnt_id] = 1'b1;
        end
    end

    assign cdc_valid_o = gnt_valid;
    assign gnt_id_o    = gnt_id;
    assign cdc_data_o  = req_data_i[int'(gnt_id)*DATA_W +: DATA_W];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            if (handshake) begin
                lock_q   <= 1'b0;
                rr_ptr_q <= rr_next;
            end else if (gnt_valid) begin
                lock_q    <= 1'b1;
                lock_id_q <= gnt_id;
            end
            if (state_q == ST_DONE) begin
                rr_ptr_q <= '0;
            end
        end
    end

`ifdef CDC_CLR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             counting;
    logic             err_q;

    assign counting = (state_q == ST_DRAIN) || (state_q == ST_WAIT_RISE) ||
                      (state_q == ST_WAIT_FALL);
    // Fires on the TIMEOUT_CYC-th cycle spent in the current waiting state.
    assign timeout  = counting && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (counting) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (state_q == ST_IDLE && clear_req_i) begin
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign clear_err_o = err_q;
`else
    assign timeout     = 1'b0;
    assign clear_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (clear_req_i) state_d = ST_DRAIN;
            // The handshake cycle itself counts as drained.
            ST_DRAIN:     if (timeout) state_d = ST_DONE;
                          else if (!lock_q || handshake) state_d = ST_ISSUE;
            ST_ISSUE:     state_d = ST_WAIT_RISE;
            ST_WAIT_RISE: if (timeout) state_d = ST_DONE;
                          else if (cdc_clear_pending_i) state_d = ST_WAIT_FALL;
            ST_WAIT_FALL: if (timeout) state_d = ST_DONE;
                          else if (!cdc_clear_pending_i) state_d = ST_DONE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cdc_clear_o  = (state_q == ST_ISSUE);
        clear_busy_o = (state_q != ST_IDLE);
        clear_done_o = (state_q == ST_DONE);
        dbg_state_o  = state_q;
    end

endmodule
